// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intc_pkg
// Description : Shared types, OCW2 command codes and helpers for the 8259A
//               compatible interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package intc_pkg;

    localparam int         LEVELS                = 8;
    localparam int         LVL_W                 = 3;
    localparam logic [2:0] RESET_PRIORITY_ROTATE = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        GAP  = 2'd2,
        ACK2 = 2'd3
    } state_t;

    // OCW2 {R, SL, EOI}
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

    // Lowest set bit index; a non-one-hot input resolves to its lowest bit.
    function automatic logic [2:0] encode(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotating_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rotating_priority_encoder
// Description : Finds the highest-priority set bit of a mask, searching from
//               priority_rotate+1 upward with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module rotating_priority_encoder
    import intc_pkg::*;
(
    input  logic [7:0] mask_i,
    input  logic [2:0] priority_rotate_i,
    output logic       valid_o,
    output logic [2:0] level_o,
    output logic [7:0] onehot_o
);

    // Scan farthest-first so the nearest candidate to rotate+1 overwrites.
    always_comb begin
        valid_o  = 1'b0;
        level_o  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_i[priority_rotate_i + 3'(i + 1)]) begin
                valid_o = 1'b1;
                level_o = priority_rotate_i + 3'(i + 1);
            end
        end
        onehot_o = valid_o ? (8'b1 << level_o) : 8'b0;
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_ack_eoi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_ack_eoi_ctrl
// Description : 8086-mode INTA sequencer, vector driver, ISR latch/EOI strobe
//               generator and OCW2 rotation-pointer owner.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_ack_eoi_ctrl
    import intc_pkg::*;
#(
    parameter int NUM_LEVELS = 8,
    parameter int LEVEL_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inta_n,
    input  logic [NUM_LEVELS-1:0] highest_request,
    input  logic [NUM_LEVELS-1:0] in_service_register,
    input  logic [4:0]            vector_base,
    input  logic                  auto_eoi,
    input  logic                  ocw2_write,
    input  logic [7:0]            ocw2_data,
    output logic                  int_out,
    output logic                  freeze,
    output logic                  latch_in_service,
    output logic [NUM_LEVELS-1:0] latched_request,
    output logic [NUM_LEVELS-1:0] end_of_interrupt,
    output logic [LEVEL_W-1:0]    priority_rotate,
    output logic [7:0]            vector_out,
    output logic                  vector_oe
);

    state_t                  state_q, state_d;
    logic                    inta_q;
    logic [LEVEL_W-1:0]      priority_rotate_q, priority_rotate_d;
    logic                    rotate_in_aeoi_q, rotate_in_aeoi_d;
    logic [LEVEL_W-1:0]      captured_level_q, captured_level_d;
    logic                    spurious_q, spurious_d;
    logic                    int_out_q, int_out_d;
    logic                    freeze_q, freeze_d;
    logic                    latch_q, latch_d;
    logic [NUM_LEVELS-1:0]   latched_request_q, latched_request_d;
    logic [NUM_LEVELS-1:0]   eoi_q, eoi_d;
    logic [7:0]              vector_out_q, vector_out_d;
    logic                    vector_oe_q, vector_oe_d;

    logic                    inta_fall, inta_rise;
    logic [2:0]              ocw2_cmd, ocw2_level;
    logic [NUM_LEVELS-1:0]   aeoi_mask, ocw2_mask;
    logic                    ns_valid;
    logic [LEVEL_W-1:0]      ns_level;
    logic [NUM_LEVELS-1:0]   ns_onehot;
    logic                    unused_ocw2;

    assign inta_fall   = inta_q & ~inta_n;
    assign inta_rise   = ~inta_q & inta_n;
    assign ocw2_cmd    = ocw2_data[7:5];
    assign ocw2_level  = ocw2_data[2:0];
    assign unused_ocw2 = ^ocw2_data[4:3];

    rotating_priority_encoder u_ns_eoi_search (
        .mask_i            (in_service_register),
        .priority_rotate_i (priority_rotate_q),
        .valid_o           (ns_valid),
        .level_o           (ns_level),
        .onehot_o          (ns_onehot)
    );

    always_comb begin
        state_d           = state_q;
        priority_rotate_d = priority_rotate_q;
        rotate_in_aeoi_d  = rotate_in_aeoi_q;
        captured_level_d  = captured_level_q;
        spurious_d        = spurious_q;
        int_out_d         = 1'b0;
        freeze_d          = freeze_q;
        latch_d           = 1'b0;
        latched_request_d = '0;
        vector_out_d      = vector_out_q;
        vector_oe_d       = vector_oe_q;
        aeoi_mask         = '0;
        ocw2_mask         = '0;

        case (state_q)
            IDLE: begin
                int_out_d = |highest_request;
                if (inta_fall) begin
                    state_d   = ACK1;
                    int_out_d = 1'b0;
                    freeze_d  = 1'b1;
                    if (|highest_request) begin
                        latch_d           = 1'b1;
                        latched_request_d = highest_request;
                        captured_level_d  = encode(highest_request);
                        spurious_d        = 1'b0;
                    end else begin
                        captured_level_d  = 3'd7;
                        spurious_d        = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) state_d = GAP;
            end
            GAP: begin
                if (inta_fall) begin
                    state_d      = ACK2;
                    vector_oe_d  = 1'b1;
                    vector_out_d = {vector_base, captured_level_q};
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_d      = IDLE;
                    vector_oe_d  = 1'b0;
                    vector_out_d = 8'h00;
                    freeze_d     = 1'b0;
                    if (auto_eoi && !spurious_q) begin
                        aeoi_mask = 8'b1 << captured_level_q;
                        if (rotate_in_aeoi_q) priority_rotate_d = captured_level_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Evaluated after the AEOI path so an OCW2 rotation takes precedence.
        if (ocw2_write) begin
            case (ocw2_cmd)
                OCW2_NS_EOI: ocw2_mask = ns_onehot;
                OCW2_SP_EOI: ocw2_mask = 8'b1 << ocw2_level;
                OCW2_ROT_NS_EOI: begin
                    ocw2_mask = ns_onehot;
                    if (ns_valid) priority_rotate_d = ns_level;
                end
                OCW2_ROT_SP_EOI: begin
                    ocw2_mask         = 8'b1 << ocw2_level;
                    priority_rotate_d = ocw2_level;
                end
                OCW2_SET_PRIO:     priority_rotate_d = ocw2_level;
                OCW2_ROT_AEOI_SET: rotate_in_aeoi_d  = 1'b1;
                OCW2_ROT_AEOI_CLR: rotate_in_aeoi_d  = 1'b0;
                default: ;
            endcase
        end

        eoi_d = aeoi_mask | ocw2_mask;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            inta_q            <= 1'b1;
            priority_rotate_q <= RESET_PRIORITY_ROTATE;
            rotate_in_aeoi_q  <= 1'b0;
            captured_level_q  <= '0;
            spurious_q        <= 1'b0;
            int_out_q         <= 1'b0;
            freeze_q          <= 1'b0;
            latch_q           <= 1'b0;
            latched_request_q <= '0;
            eoi_q             <= '0;
            vector_out_q      <= 8'h00;
            vector_oe_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            inta_q            <= inta_n;
            priority_rotate_q <= priority_rotate_d;
            rotate_in_aeoi_q  <= rotate_in_aeoi_d;
            captured_level_q  <= captured_level_d;
            spurious_q        <= spurious_d;
            int_out_q         <= int_out_d;
            freeze_q          <= freeze_d;
            latch_q           <= latch_d;
            latched_request_q <= latched_request_d;
            eoi_q             <= eoi_d;
            vector_out_q      <= vector_out_d;
            vector_oe_q       <= vector_oe_d;
        end
    end

    assign int_out          = int_out_q;
    assign freeze           = freeze_q;
    assign latch_in_service = latch_q;
    assign latched_request  = latched_request_q;
    assign end_of_interrupt = eoi_q;
    assign priority_rotate  = priority_rotate_q;
    assign vector_out       = vector_out_q;
    assign vector_oe        = vector_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_ack_eoi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_ack_eoi_ctrl
// Description : Directed self-checking bench for interrupt_ack_eoi_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_ack_eoi_ctrl;

    logic       clk;
    logic       reset_n;
    logic       inta_n;
    logic [7:0] highest_request;
    logic [7:0] in_service_register;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       ocw2_write;
    logic [7:0] ocw2_data;
    logic       int_out;
    logic       freeze;
    logic       latch_in_service;
    logic [7:0] latched_request;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic [7:0] vector_out;
    logic       vector_oe;

    int errors = 0;
    int checks = 0;

    interrupt_ack_eoi_ctrl #(.NUM_LEVELS(8), .LEVEL_W(3)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .inta_n              (inta_n),
        .highest_request     (highest_request),
        .in_service_register (in_service_register),
        .vector_base         (vector_base),
        .auto_eoi            (auto_eoi),
        .ocw2_write          (ocw2_write),
        .ocw2_data           (ocw2_data),
        .int_out             (int_out),
        .freeze              (freeze),
        .latch_in_service    (latch_in_service),
        .latched_request     (latched_request),
        .end_of_interrupt    (end_of_interrupt),
        .priority_rotate     (priority_rotate),
        .vector_out          (vector_out),
        .vector_oe           (vector_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic inta_low();
        inta_n = 1'b0;
        tick();
    endtask

    task automatic inta_high();
        inta_n = 1'b1;
        tick();
    endtask

    task automatic ocw2(input logic [7:0] d);
        ocw2_write = 1'b1;
        ocw2_data  = d;
        tick();
        ocw2_write = 1'b0;
        ocw2_data  = 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; inta_n = 1'b1; highest_request = 8'h00; in_service_register = 8'h00;
        vector_base = 5'b01000; auto_eoi = 1'b0; ocw2_write = 1'b0; ocw2_data = 8'h00;
        tick(); tick();
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int_out: got %b want 0", int_out); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %b want 0", freeze); end
        checks++; if (latch_in_service !== 1'b0 || latched_request !== 8'h00) begin errors++; $display("FAIL reset_latch: got %b/%h want 0/00", latch_in_service, latched_request); end
        checks++; if (end_of_interrupt !== 8'h00) begin errors++; $display("FAIL reset_eoi: got %h want 00", end_of_interrupt); end
        checks++; if (priority_rotate !== 3'd7) begin errors++; $display("FAIL reset_rotate: got %0d want 7", priority_rotate); end
        checks++; if (vector_oe !== 1'b0 || vector_out !== 8'h00) begin errors++; $display("FAIL reset_vector: got %b/%h want 0/00", vector_oe, vector_out); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_normal_ack();
        highest_request = 8'h04; vector_base = 5'b01000; auto_eoi = 1'b0;
        tick();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL ack_int_req: got %b want 1", int_out); end
        inta_low();
        checks++; if (latch_in_service !== 1'b1 || latched_request !== 8'h04) begin errors++; $display("FAIL ack_latch: got %b/%h want 1/04", latch_in_service, latched_request); end
        checks++; if (freeze !== 1'b1 || int_out !== 1'b0) begin errors++; $display("FAIL ack_freeze_int: got %b/%b want 1/0", freeze, int_out); end
        tick();
        checks++; if (latch_in_service !== 1'b0) begin errors++; $display("FAIL ack_latch_one_cycle: got %b want 0", latch_in_service); end
        inta_high();
        tick();
        checks++; if (int_out !== 1'b0 || vector_oe !== 1'b0) begin errors++; $display("FAIL ack_gap: int %b oe %b want 0/0", int_out, vector_oe); end
        inta_low();
        checks++; if (vector_oe !== 1'b1 || vector_out !== 8'h42) begin errors++; $display("FAIL ack_vector: got %b/%h want 1/42", vector_oe, vector_out); end
        tick();
        checks++; if (vector_oe !== 1'b1 || vector_out !== 8'h42 || end_of_interrupt !== 8'h00) begin errors++; $display("FAIL ack_vector_hold: got %b/%h eoi %h want 1/42 eoi 00", vector_oe, vector_out, end_of_interrupt); end
        inta_high();
        checks++; if (vector_oe !== 1'b0 || vector_out !== 8'h00 || freeze !== 1'b0) begin errors++; $display("FAIL ack_end: oe %b vec %h frz %b want 0/00/0", vector_oe, vector_out, freeze); end
        checks++; if (end_of_interrupt !== 8'h00 || int_out !== 1'b0) begin errors++; $display("FAIL ack_end_eoi: eoi %h int %b want 00/0", end_of_interrupt, int_out); end
        tick();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL ack_int_reeval: got %b want 1", int_out); end
    endtask

    task automatic test_aeoi_rotate();
        auto_eoi = 1'b1;
        ocw2(8'h80);
        highest_request = 8'h20;
        tick();
        inta_low(); inta_high(); inta_low();
        checks++; if (vector_out !== 8'h45) begin errors++; $display("FAIL aeoi_vector: got %h want 45", vector_out); end
        inta_high();
        checks++; if (end_of_interrupt !== 8'h20 || priority_rotate !== 3'd5) begin errors++; $display("FAIL aeoi_eoi_rot: got %h/%0d want 20/5", end_of_interrupt, priority_rotate); end
        tick();
        checks++; if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'd5) begin errors++; $display("FAIL aeoi_one_cycle: got %h/%0d want 00/5", end_of_interrupt, priority_rotate); end
        ocw2(8'h00);
        auto_eoi = 1'b0;
    endtask

    task automatic test_nseoi_rotate();
        ocw2(8'hC3);
        checks++; if (priority_rotate !== 3'd3 || end_of_interrupt !== 8'h00) begin errors++; $display("FAIL set_prio: got %0d/%h want 3/00", priority_rotate, end_of_interrupt); end
        in_service_register = 8'h11;
        ocw2(8'h20);
        checks++; if (end_of_interrupt !== 8'h10 || priority_rotate !== 3'd3) begin errors++; $display("FAIL ns_eoi: got %h/%0d want 10/3", end_of_interrupt, priority_rotate); end
        tick();
        checks++; if (end_of_interrupt !== 8'h00) begin errors++; $display("FAIL ns_eoi_one_cycle: got %h want 00", end_of_interrupt); end
        in_service_register = 8'h01;
        ocw2(8'hA0);
        checks++; if (end_of_interrupt !== 8'h01 || priority_rotate !== 3'd0) begin errors++; $display("FAIL rot_ns_eoi_wrap: got %h/%0d want 01/0", end_of_interrupt, priority_rotate); end
        ocw2(8'hC5);
        in_service_register = 8'h00;
        ocw2(8'hA0);
        checks++; if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'd5) begin errors++; $display("FAIL ns_eoi_empty: got %h/%0d want 00/5", end_of_interrupt, priority_rotate); end
        ocw2(8'h63);
        checks++; if (end_of_interrupt !== 8'h08) begin errors++; $display("FAIL sp_eoi_clear_bit: got %h want 08", end_of_interrupt); end
        ocw2(8'h40);
        checks++; if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'd5) begin errors++; $display("FAIL ocw2_nop: got %h/%0d want 00/5", end_of_interrupt, priority_rotate); end
    endtask

    task automatic test_spurious();
        highest_request = 8'h00; auto_eoi = 1'b1;
        tick();
        inta_low();
        checks++; if (latch_in_service !== 1'b0 || freeze !== 1'b1) begin errors++; $display("FAIL spur_latch: got %b frz %b want 0/1", latch_in_service, freeze); end
        inta_high(); inta_low();
        checks++; if (vector_oe !== 1'b1 || vector_out !== 8'h47) begin errors++; $display("FAIL spur_vector: got %b/%h want 1/47", vector_oe, vector_out); end
        inta_high();
        checks++; if (end_of_interrupt !== 8'h00 || freeze !== 1'b0 || priority_rotate !== 3'd5) begin errors++; $display("FAIL spur_no_eoi: eoi %h frz %b rot %0d want 00/0/5", end_of_interrupt, freeze, priority_rotate); end
        auto_eoi = 1'b0;
    endtask

    task automatic test_collision();
        auto_eoi = 1'b1; highest_request = 8'h04;
        tick();
        inta_low(); inta_high(); inta_low();
        inta_n = 1'b1; ocw2(8'h61);
        checks++; if (end_of_interrupt !== 8'h06 || priority_rotate !== 3'd5) begin errors++; $display("FAIL collide_eoi: got %h/%0d want 06/5", end_of_interrupt, priority_rotate); end
        ocw2(8'h80);
        inta_low(); inta_high(); inta_low();
        inta_n = 1'b1; ocw2(8'hE1);
        checks++; if (end_of_interrupt !== 8'h06 || priority_rotate !== 3'd1) begin errors++; $display("FAIL collide_rotate: got %h/%0d want 06/1", end_of_interrupt, priority_rotate); end
        ocw2(8'h00);
        auto_eoi = 1'b0;
    endtask

    task automatic test_reset_mid();
        highest_request = 8'h04;
        tick();
        inta_low(); inta_high();
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL mid_pre_freeze: got %b want 1", freeze); end
        reset_n = 1'b0;
        #1;
        checks++; if (freeze !== 1'b0 || vector_oe !== 1'b0 || priority_rotate !== 3'd7 || end_of_interrupt !== 8'h00) begin errors++; $display("FAIL mid_async_reset: frz %b oe %b rot %0d eoi %h want 0/0/7/00", freeze, vector_oe, priority_rotate, end_of_interrupt); end
        tick();
        reset_n = 1'b1;
        highest_request = 8'h02;
        tick(); tick();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL mid_int: got %b want 1", int_out); end
        inta_low();
        checks++; if (latch_in_service !== 1'b1 || latched_request !== 8'h02) begin errors++; $display("FAIL mid_relatch: got %b/%h want 1/02", latch_in_service, latched_request); end
        inta_high(); inta_low();
        checks++; if (vector_oe !== 1'b1 || vector_out !== 8'h41) begin errors++; $display("FAIL mid_vector: got %b/%h want 1/41", vector_oe, vector_out); end
        inta_high();
        checks++; if (vector_oe !== 1'b0 || freeze !== 1'b0 || end_of_interrupt !== 8'h00) begin errors++; $display("FAIL mid_end: oe %b frz %b eoi %h want 0/0/00", vector_oe, freeze, end_of_interrupt); end
    endtask

    initial begin
        test_reset();
        test_normal_ack();
        test_aeoi_rotate();
        test_nseoi_rotate();
        test_spurious();
        test_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_ack_eoi_ctrl.md
Name: interrupt_ack_eoi_ctrl

Overview:
- Control-logic end of the in-service interface for the 8259A-compatible controller, 8086 mode only.
- Runs the two-pulse INTA acknowledge sequence and raises INT to the CPU.
- Produces the latch_in_service and end_of_interrupt strobes consumed by the in-service register, and drives the vector byte.
- Decodes OCW2 EOI/rotate commands and owns the rotation pointer (priority_rotate) shared with the priority resolver and the ISR.

Parameters:
- NUM_LEVELS, 8, number of interrupt levels (fixed at 8; present for readability only).
- LEVEL_W, 3, width of an encoded level.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- inta_n  input  1  CPU acknowledge, already synchronised to clk.
- highest_request  input  8  one-hot winning request from the priority resolver; all-zero means none.
- in_service_register  input  8  current ISR contents.
- vector_base  input  5  T7..T3 from ICW2.
- auto_eoi  input  1  AEOI mode from ICW4.
- ocw2_write  input  1  one-cycle strobe; ocw2_data is valid in that cycle.
- ocw2_data  input  8  bits [7:5] = R, SL, EOI; bits [2:0] = L.
- int_out  output  1  INT to the CPU.
- freeze  output  1  holds the request latches during acknowledge.
- latch_in_service  output  1  one-cycle strobe; highest_request is loaded into the ISR.
- latched_request  output  8  one-hot value to OR into the ISR when latch_in_service is high.
- end_of_interrupt  output  8  one-cycle one-hot clear mask.
- priority_rotate  output  3  lowest-priority level; highest priority = priority_rotate+1 mod 8.
- vector_out  output  8  vector byte.
- vector_oe  output  1  vector_out is valid and driven.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, inta_q=1, priority_rotate=3'd7, rotate_in_aeoi=0, captured_level=0, spurious=0.
  - All strobes and masks 0; int_out=0, freeze=0, vector_oe=0, vector_out=0.
  - Reset asserted mid-sequence aborts it with no EOI generated.
- Edge detect: inta_q is inta_n registered. fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
- State machine (registered; strobes are registered outputs, one cycle after the detected edge):
  - IDLE: int_out=1 while highest_request!=0. On fall go to ACK1.
    - If highest_request!=0: latch_in_service=1, latched_request=highest_request, captured_level=encode(highest_request), spurious=0.
    - Else: spurious=1, captured_level=7, no latch strobe.
    - In both cases int_out=0, freeze=1.
  - ACK1: on rise go to GAP.
  - GAP: on fall go to ACK2 and set vector_oe=1, vector_out={vector_base, captured_level}. There is no timeout.
  - ACK2: vector_oe and vector_out are held while inta_n=0. On rise go to IDLE, with vector_oe=0, vector_out=0, freeze=0.
    - If auto_eoi and !spurious: end_of_interrupt=1<<captured_level.
    - Additionally, if rotate_in_aeoi: priority_rotate=captured_level.
- int_out stays 0 from ACK1 through ACK2. It re-evaluates in the cycle after returning to IDLE.
- OCW2 decode on ocw2_write, by {R,SL,EOI}; takes effect next cycle:
  - 001 non-specific EOI: clear the highest-priority set ISR bit, searched from priority_rotate+1 upward with wrap.
  - 011 specific EOI: clear bit L.
  - 101 rotate on non-specific EOI: as 001, plus priority_rotate=the cleared level.
  - 111 rotate on specific EOI: clear bit L, priority_rotate=L.
  - 110 set priority: priority_rotate=L, no clear.
  - 100: rotate_in_aeoi=1. 000: rotate_in_aeoi=0. 010: no-op.
- Non-specific EOI with ISR=0: no clear pulse and no rotate.
- Specific EOI on an ISR bit that is already 0: the pulse is still issued; this is harmless.
- Simultaneous events:
  - An OCW2 EOI and an AEOI completing in the same cycle: end_of_interrupt is the OR of both masks.
  - If both would rotate, the OCW2 rotation wins.
  - An OCW2 EOI in the same cycle as latch_in_service is legal and independent.
- Width rules: all level arithmetic is modulo 8 on 3 bits. encode() of a non-one-hot input returns its lowest set bit index.

Decomposition:
- Shared package intc_pkg:
  - State enum IDLE/ACK1/GAP/ACK2.
  - OCW2 command codes (3-bit constants above).
  - RESET_PRIORITY_ROTATE=3'd7.
- Sub-module rotating_priority_encoder: combinational. Inputs are an 8-bit mask and priority_rotate. Outputs are valid, level[2:0] and a one-hot. It is used for the non-specific EOI search and is reusable by the priority resolver.

Test Plan:
- Normal acknowledge: highest_request=8'h04, vector_base=5'b01000, auto_eoi=0, two INTA pulses.
  - Expect latch_in_service for 1 cycle with latched_request=8'h04.
  - Expect vector_out=8'h42 with vector_oe=1 during pulse 2, and end_of_interrupt=0 throughout.
- AEOI with rotation: auto_eoi=1, OCW2=8'h80 (set rotate_in_aeoi), highest_request=8'h20.
  - After the second INTA rising edge expect end_of_interrupt=8'h20 for one cycle and priority_rotate=5.
- Non-specific EOI with rotation: priority_rotate=3, ISR=8'h11, OCW2=8'h20.
  - Expect end_of_interrupt=8'h10 (level 4 is the highest priority).
  - Then with ISR=8'h01, OCW2=8'hA0: expect 8'h01 and priority_rotate=0.
- Spurious acknowledge: highest_request=0 at the first INTA fall.
  - Expect no latch strobe and vector_out={base,3'd7}.
  - With auto_eoi=1, expect no end_of_interrupt.
- Collision: AEOI completing for level 2 in the same cycle as OCW2=8'h61 (specific EOI, level 1).
  - Expect end_of_interrupt=8'h06.
- Reset mid-sequence: assert reset_n=0 while in GAP.
  - Expect freeze=0, vector_oe=0, priority_rotate=7 and state IDLE immediately (asynchronous).
  - After release, the next INTA pair sequences normally.
